// File: rtl/ex_mem_reg.sv
// EX->MEM pipeline register with MADD/MSUB partial-result hold; 1-cycle latency.
// Priority: flush > bubble (stall_ex & !stall_mem) > advance (!stall_ex) > hold.
module ex_mem_reg #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall_ex,
    input  logic                stall_mem,
    input  logic                flush,
    input  logic                ex_en_wd,
    input  logic [ADDR_W-1:0]   ex_desReg_addr,
    input  logic [DATA_W-1:0]   ex_result,
    input  logic [DATA_W-1:0]   ex_hi,
    input  logic [DATA_W-1:0]   ex_lo,
    input  logic                ex_en_hilo,
    input  logic [2*DATA_W-1:0] hilo_temp_i,
    input  logic [CNT_W-1:0]    cnt_i,
    output logic                en_wd,
    output logic [ADDR_W-1:0]   desReg_addr,
    output logic [DATA_W-1:0]   result,
    output logic [DATA_W-1:0]   hi_o,
    output logic [DATA_W-1:0]   lo_o,
    output logic                en_hilo_o,
    output logic [2*DATA_W-1:0] hilo_temp_o,
    output logic [CNT_W-1:0]    cnt_o
);

    logic                en_wd_q,     en_wd_d;
    logic [ADDR_W-1:0]   addr_q,      addr_d;
    logic [DATA_W-1:0]   result_q,    result_d;
    logic [DATA_W-1:0]   hi_q,        hi_d;
    logic [DATA_W-1:0]   lo_q,        lo_d;
    logic                en_hilo_q,   en_hilo_d;
    logic [2*DATA_W-1:0] hilo_temp_q, hilo_temp_d;
    logic [CNT_W-1:0]    cnt_q,       cnt_d;

    always_comb begin
        en_wd_d     = en_wd_q;
        addr_d      = addr_q;
        result_d    = result_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        en_hilo_d   = en_hilo_q;
        hilo_temp_d = hilo_temp_q;
        cnt_d       = cnt_q;
        if (flush) begin
            en_wd_d     = 1'b0;
            addr_d      = '0;
            result_d    = '0;
            hi_d        = '0;
            lo_d        = '0;
            en_hilo_d   = 1'b0;
            hilo_temp_d = '0;
            cnt_d       = '0;
        end else if (stall_ex && !stall_mem) begin
            // Bubble into MEM, but keep the accumulate state alive for the next EX pass.
            en_wd_d     = 1'b0;
            addr_d      = '0;
            result_d    = '0;
            hi_d        = '0;
            lo_d        = '0;
            en_hilo_d   = 1'b0;
            hilo_temp_d = hilo_temp_i;
            cnt_d       = cnt_i;
        end else if (!stall_ex && !stall_mem) begin
            en_wd_d     = ex_en_wd;
            addr_d      = ex_desReg_addr;
            result_d    = ex_result;
            hi_d        = ex_hi;
            lo_d        = ex_lo;
            en_hilo_d   = ex_en_hilo;
            hilo_temp_d = '0;
            cnt_d       = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_wd_q     <= 1'b0;
            addr_q      <= '0;
            result_q    <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            en_hilo_q   <= 1'b0;
            hilo_temp_q <= '0;
            cnt_q       <= '0;
        end else begin
            en_wd_q     <= en_wd_d;
            addr_q      <= addr_d;
            result_q    <= result_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            en_hilo_q   <= en_hilo_d;
            hilo_temp_q <= hilo_temp_d;
            cnt_q       <= cnt_d;
        end
    end

    assign en_wd       = en_wd_q;
    assign desReg_addr = addr_q;
    assign result      = result_q;
    assign hi_o        = hi_q;
    assign lo_o        = lo_q;
    assign en_hilo_o   = en_hilo_q;
    assign hilo_temp_o = hilo_temp_q;
    assign cnt_o       = cnt_q;

endmodule
